// File: rtl/vm_pkg.sv
// Shared vending-machine types: amount widths, coin values, dispenser states.
// DISPENSE_TIMEOUT_EN adds the FAULT state for hopper timeouts.
package vm_pkg;

    localparam int W     = 13;
    localparam int CNT_W = 11;

    localparam logic [W-1:0] DEN0 = W'(100);
    localparam logic [W-1:0] DEN1 = W'(25);
    localparam logic [W-1:0] DEN2 = W'(10);
    localparam logic [W-1:0] DEN3 = W'(5);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        RELEASE,
`ifdef DISPENSE_TIMEOUT_EN
        DONE,
        FAULT
`else
        DONE
`endif
    } state_t;

    function automatic logic [W-1:0] den_of(input logic [1:0] sel);
        logic [W-1:0] d;
        d = DEN3;
        case (sel)
            2'd0:    d = DEN0;
            2'd1:    d = DEN1;
            2'd2:    d = DEN2;
            default: d = DEN3;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Host and hopper signals of the change dispenser.
// master drives start/amount/coin_ack; slave is the dispenser.
interface change_dispenser_if;
    import vm_pkg::*;

    logic             start;
    logic [W-1:0]     amount;
    logic [3:0]       coin_ack;
    logic [3:0]       coin_req;
    logic             busy;
    logic             done;
    logic [W-1:0]     remaining;
    logic [CNT_W-1:0] coins_paid;
    logic             fault;

    modport master (
        output start, amount, coin_ack,
        input  coin_req, busy, done,
        input  remaining, coins_paid, fault
    );

    modport slave (
        input  start, amount, coin_ack,
        output coin_req, busy, done,
        output remaining, coins_paid, fault
    );

endinterface

// File: rtl/denom_select.sv
// Greedy coin picker: largest coin not exceeding the remaining amount.
// valid is low when nothing fits (remaining below the smallest coin).
module denom_select
    import vm_pkg::*;
(
    input  logic [W-1:0] remaining,
    output logic [1:0]   sel,
    output logic         valid
);

    always_comb begin
        sel   = 2'd0;
        valid = 1'b1;
        if (remaining >= DEN0)
            sel = 2'd0;
        else if (remaining >= DEN1)
            sel = 2'd1;
        else if (remaining >= DEN2)
            sel = 2'd2;
        else if (remaining >= DEN3)
            sel = 2'd3;
        else
            valid = 1'b0;
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out change greedily through four hoppers with 4-phase req/ack.
// DISPENSE_TIMEOUT_EN adds a sticky hopper-timeout fault.
module change_dispenser
    import vm_pkg::*;
`ifdef DISPENSE_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 100000000
)
`endif
(
    input logic                clk,
    input logic                reset,
    change_dispenser_if.slave  bus
);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       req_q, req_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pick;
    logic             pick_valid;

    denom_select u_sel (
        .remaining (rem_q),
        .sel       (pick),
        .valid     (pick_valid)
    );

`ifdef DISPENSE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             fault_q, fault_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            req_q   <= 4'd0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DISPENSE_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        req_d   = req_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d   = bus.amount;
                    cnt_d   = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (pick_valid) begin
                    sel_d   = pick;
                    req_d   = 4'b0001 << pick;
                    state_d = REQ;
                end else begin
                    state_d = DONE;
                end
            end
            REQ: begin
                // Only the requested hopper's ack counts.
                if (bus.coin_ack[sel_q]) begin
                    rem_d = rem_q - den_of(sel_q);
                    if (cnt_q != '1)
                        cnt_d = cnt_q + CNT_W'(1);
                    req_d   = 4'd0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (bus.coin_ack == 4'd0)
                    state_d = SELECT;
            end
            DONE: begin
                state_d = IDLE;
            end
`ifdef DISPENSE_TIMEOUT_EN
            FAULT: begin
                state_d = FAULT;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DISPENSE_TIMEOUT_EN
        tmo_d   = '0;
        fault_d = fault_q;
        // Count cycles spent waiting on a hopper in the same state.
        if ((state_q == REQ || state_q == RELEASE)
            && state_d == state_q) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                req_d   = 4'd0;
                fault_d = 1'b1;
                state_d = FAULT;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif
    end

    assign bus.coin_req   = req_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.remaining  = rem_q;
    assign bus.coins_paid = cnt_q;
`ifdef DISPENSE_TIMEOUT_EN
    assign bus.fault      = fault_q;
`else
    assign bus.fault      = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: vector table plus hand-written corner sequences.
// A hopper model answers requests; expected coins are queued at each start.
module tb_change_dispenser;
    import vm_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    change_dispenser_if bus ();

    change_dispenser dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [12:0] amount;
        int          delay;
        logic [12:0] rem;
        logic [10:0] coins;
    } vec_t;

    int         nvec = 0;
    int         nmis = 0;
    int         exp_q[$];
    int         ack_delay = 3;
    logic [3:0] spur = 4'd0;
    logic [3:0] hop_ack = 4'd0;
    vec_t       tbl[6];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic void push_greedy(input int amt);
        int dens[4];
        int a;
        dens = '{100, 25, 10, 5};
        a = amt;
        for (int i = 0; i < 4; i++)
            while (a >= dens[i]) begin
                exp_q.push_back(i);
                a -= dens[i];
            end
    endfunction

    // Hopper: ack after ack_delay cycles, release once req drops.
    initial begin
        int cnt;
        cnt = 0;
        bus.coin_ack = 4'd0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                hop_ack = 4'd0;
                cnt = 0;
            end else if (hop_ack == 4'd0 && bus.coin_req != 4'd0) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    hop_ack = bus.coin_req;
                    cnt = 0;
                end
            end else if (hop_ack != 4'd0 && bus.coin_req == 4'd0) begin
                hop_ack = 4'd0;
            end
            bus.coin_ack = hop_ack | spur;
        end
    end

    // Every new request must be the next coin the model expects.
    initial begin
        logic [3:0] prev;
        prev = 4'd0;
        forever begin
            @(negedge clk);
            if (!reset && bus.coin_req != 4'd0 && prev == 4'd0) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_req: got %b want none",
                             bus.coin_req);
                end else begin
                    int h;
                    h = exp_q.pop_front();
                    check("coin_req", 32'(bus.coin_req),
                          32'(4'b0001 << h));
                end
            end
            prev = reset ? 4'd0 : bus.coin_req;
        end
    end

    task automatic pulse_start(input logic [12:0] amt);
        @(negedge clk);
        bus.amount = amt;
        bus.start  = 1'b1;
        push_greedy(int'(amt));
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(input string name,
                             input logic [12:0] rem,
                             input logic [10:0] coins,
                             output int lat);
        int n;
        n = 0;
        check({name, "_busy"}, 32'(bus.busy), 32'd1);
        while (!bus.done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        if (!bus.done) begin
            nvec++;
            nmis++;
            $display("FAIL %s_timeout: got no done want done", name);
        end else begin
            check({name, "_rem"}, 32'(bus.remaining), 32'(rem));
            check({name, "_coins"}, 32'(bus.coins_paid), 32'(coins));
            check({name, "_left"}, 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            check({name, "_pulse"}, 32'(bus.done), 32'd0);
            check({name, "_idle"}, 32'(bus.busy), 32'd0);
        end
        exp_q.delete();
    endtask

    task automatic wait_req(input logic [3:0] v);
        int n;
        n = 0;
        while (bus.coin_req != v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_req", 32'(bus.coin_req), 32'(v));
    endtask

    initial begin
        int lat;
        tbl[0] = '{13'd140,  3, 13'd0, 11'd4};
        tbl[1] = '{13'd0,    3, 13'd0, 11'd0};
        tbl[2] = '{13'd7,    3, 13'd2, 11'd1};
        tbl[3] = '{13'd25,   1, 13'd0, 11'd1};
        tbl[4] = '{13'd99,   2, 13'd4, 11'd5};
        tbl[5] = '{13'd8191, 1, 13'd1, 11'd86};

        bus.start  = 1'b0;
        bus.amount = '0;
        reset = 1'b1;
        #12;
        check("rst_req", 32'(bus.coin_req), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rem", 32'(bus.remaining), 32'd0);
        check("rst_coins", 32'(bus.coins_paid), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            ack_delay = tbl[i].delay;
            pulse_start(tbl[i].amount);
            wait_done($sformatf("vec%0d", i), tbl[i].rem,
                      tbl[i].coins, lat);
            if (tbl[i].amount == 13'd0)
                check("zero_latency", 32'(lat), 32'd1);
        end

        // Second start and a stray hopper-3 ack mid-payout are ignored.
        ack_delay = 3;
        pulse_start(13'd210);
        wait_req(4'b0001);
        spur = 4'b1000;
        bus.amount = 13'd5;
        bus.start  = 1'b1;
        @(negedge clk);
        spur = 4'd0;
        bus.start  = 1'b0;
        wait_done("busy_start", 13'd0, 11'd3, lat);

        // Asynchronous reset mid-request abandons the payout.
        pulse_start(13'd140);
        wait_req(4'b0001);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(bus.coin_req), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_rem", 32'(bus.remaining), 32'd0);
        check("mid_rst_coins", 32'(bus.coins_paid), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        pulse_start(13'd25);
        wait_done("after_rst", 13'd0, 11'd1, lat);

        check("fault_low", 32'(bus.fault), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
